// File: rtl/tt_ctrl_sel_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_ctrl_sel_seq_if
// Purpose  : Request/status bundle between a requester and the select
//            sequencer. The requester (master) presents a target design
//            address plus the final enable value. The sequencer (slave)
//            reports progress and the tracked counter value.
// Signals  : req_valid/req_ready/req_addr/req_ena - address request
//            busy/done                          - sequence progress
//            cur_addr/cur_valid                 - tracked counter value
// Revision : 1.0 - initial release
// ============================================================================
interface tt_ctrl_sel_seq_if #(
  parameter int SEL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_addr;
  logic             req_ena;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] cur_addr;
  logic             cur_valid;

  modport master (
    output req_valid, req_addr, req_ena,
    input  req_ready, busy, done, cur_addr, cur_valid
  );

  modport slave (
    input  req_valid, req_addr, req_ena,
    output req_ready, busy, done, cur_addr, cur_valid
  );
endinterface
`default_nettype wire

// File: rtl/tt_ctrl_sel_seq.sv
`default_nettype none
// ============================================================================
// Module   : tt_ctrl_sel_seq
// Purpose  : Turns "select design A, enable yes/no" requests into the pulse
//            train the mux controller needs: disable, optional counter reset,
//            A (or A - current) increment pulses, settle time, then enable.
//            The counter value is tracked so forward moves skip the reset.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            bus (slave)     - request handshake and status
//            ctrl_sel_rst_n  - active-low select counter reset (registered)
//            ctrl_sel_inc    - select counter increment pulse (registered)
//            ctrl_ena        - design enable (registered)
// Revision : 1.0 - initial release
// ============================================================================
module tt_ctrl_sel_seq #(
  parameter int SEL_W      = 10,
  parameter int RST_CYC    = 4,
  parameter int INC_HI     = 2,
  parameter int INC_LO     = 2,
  parameter int SETTLE_CYC = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  tt_ctrl_sel_seq_if.slave     bus,
  output logic                 ctrl_sel_rst_n,
  output logic                 ctrl_sel_inc,
  output logic                 ctrl_ena
);

  localparam int C_MAX_A = (RST_CYC > INC_HI) ? RST_CYC : INC_HI;
  localparam int C_MAX_B = (INC_LO > SETTLE_CYC) ? INC_LO : SETTLE_CYC;
  localparam int C_MAXP  = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_TW    = $clog2(C_MAXP) + 1;

  // Terminal timer values: each timed state exits when the timer reaches N-1.
  localparam logic [C_TW-1:0] C_RST_LAST    = C_TW'(RST_CYC - 1);
  localparam logic [C_TW-1:0] C_INCH_LAST   = C_TW'(INC_HI - 1);
  localparam logic [C_TW-1:0] C_INCL_LAST   = C_TW'(INC_LO - 1);
  localparam logic [C_TW-1:0] C_SETTLE_LAST = C_TW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIS    = 3'd1,
    S_RST    = 3'd2,
    S_INC_H  = 3'd3,
    S_INC_L  = 3'd4,
    S_SETTLE = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t           r_state;
  logic [C_TW-1:0]  r_tmr;
  logic [SEL_W-1:0] r_npulse;
  logic [SEL_W-1:0] r_cur_addr;
  logic             r_cur_valid;
  logic             r_need_rst;
  logic             r_ena;
  logic             r_done;

  assign bus.req_ready = (r_state == S_IDLE) & ~rst;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.cur_addr  = r_cur_addr;
  assign bus.cur_valid = r_cur_valid;

  // Outputs are updated on the transition into each state so that the
  // registered ctrl_* values always match the state being occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tmr          <= '0;
      r_npulse       <= '0;
      r_cur_addr     <= '0;
      r_cur_valid    <= 1'b0;
      r_need_rst     <= 1'b0;
      r_ena          <= 1'b0;
      r_done         <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Until the first reset phase completes, the counter value is
          // unknown, so the counter is kept held in reset.
          if (bus.req_valid) begin
            r_ena <= bus.req_ena;
            r_tmr <= '0;
            if (r_cur_valid && (bus.req_addr == r_cur_addr)) begin
              r_state <= S_FINISH;
            end else begin
              ctrl_ena <= 1'b0;
              r_state  <= S_DIS;
              if (r_cur_valid && (bus.req_addr > r_cur_addr)) begin
                r_need_rst <= 1'b0;
                r_npulse   <= bus.req_addr - r_cur_addr;
              end else begin
                r_need_rst <= 1'b1;
                r_npulse   <= bus.req_addr;
              end
            end
          end
        end

        S_DIS: begin
          // Without a reset the plan is always a strict forward move, so
          // at least one pulse is pending here.
          if (r_need_rst) begin
            ctrl_sel_rst_n <= 1'b0;
            r_state        <= S_RST;
          end else begin
            ctrl_sel_inc <= 1'b1;
            r_cur_addr   <= r_cur_addr + SEL_W'(1);
            r_state      <= S_INC_H;
          end
        end

        S_RST: begin
          if (r_tmr == C_RST_LAST) begin
            r_tmr          <= '0;
            ctrl_sel_rst_n <= 1'b1;
            r_cur_valid    <= 1'b1;
            if (r_npulse != '0) begin
              // Counter leaves reset at 0 and the first pulse starts now.
              ctrl_sel_inc <= 1'b1;
              r_cur_addr   <= SEL_W'(1);
              r_state      <= S_INC_H;
            end else begin
              r_cur_addr <= '0;
              r_state    <= S_SETTLE;
            end
          end else begin
            r_tmr <= r_tmr + C_TW'(1);
          end
        end

        S_INC_H: begin
          if (r_tmr == C_INCH_LAST) begin
            r_tmr        <= '0;
            ctrl_sel_inc <= 1'b0;
            r_state      <= S_INC_L;
          end else begin
            r_tmr <= r_tmr + C_TW'(1);
          end
        end

        S_INC_L: begin
          if (r_tmr == C_INCL_LAST) begin
            r_tmr    <= '0;
            r_npulse <= r_npulse - SEL_W'(1);
            if (r_npulse != SEL_W'(1)) begin
              ctrl_sel_inc <= 1'b1;
              r_cur_addr   <= r_cur_addr + SEL_W'(1);
              r_state      <= S_INC_H;
            end else begin
              r_state <= S_SETTLE;
            end
          end else begin
            r_tmr <= r_tmr + C_TW'(1);
          end
        end

        S_SETTLE: begin
          if (r_tmr == C_SETTLE_LAST) begin
            r_tmr   <= '0;
            r_state <= S_FINISH;
          end else begin
            r_tmr <= r_tmr + C_TW'(1);
          end
        end

        S_FINISH: begin
          ctrl_ena <= r_ena;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
